// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single slave port, with a per-grant
// wait timeout that returns an error response and latches a sticky error record.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        err_clear,
  output logic        err_flag,
  output logic [31:0] err_addr,
  output logic        err_master
);

  // state    | meaning
  // IDLE     | no grant; arbitrate among valid requesters
  // GRANT0   | requester 0 owns the slave port
  // GRANT1   | requester 1 owns the slave port
  // ERR_RESP | one-cycle error completion to the timed-out owner
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, ERR_RESP} state_t;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        r_owner;
  logic [15:0] r_cnt;
  logic        r_err_flag;
  logic [31:0] r_err_addr;
  logic        r_err_master;

  logic        w_granted;
  logic        w_sel;
  logic        w_mvalid;
  logic [31:0] w_maddr;
  logic        w_done;
  logic        w_timeout;
  logic        w_capture;

  always_comb begin
    w_granted = (r_state == GRANT0) || (r_state == GRANT1);
    w_sel     = (r_state == GRANT1);
    w_mvalid  = w_sel ? m1_valid : m0_valid;
    w_maddr   = w_sel ? m1_addr : m0_addr;
    w_done    = w_granted && w_mvalid && s_ready;
    // A ready in the final wait cycle wins over the timeout.
    w_timeout = w_granted && w_mvalid && !s_ready && (r_cnt == LP_CNT_LAST);
    // A new capture overrides a clear arriving in the same cycle.
    w_capture = w_timeout && (!r_err_flag || err_clear);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (m0_valid && m1_valid) w_next = r_last ? GRANT0 : GRANT1;
        else if (m0_valid)        w_next = GRANT0;
        else if (m1_valid)        w_next = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!w_mvalid || s_ready) w_next = IDLE;
        else if (w_timeout)       w_next = ERR_RESP;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_valid  = 1'b0;
    s_instr  = 1'b0;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    s_wstrb  = 4'b0;
    m0_ready = 1'b0;
    m0_rdata = 32'h0;
    m1_ready = 1'b0;
    m1_rdata = 32'h0;
    case (r_state)
      GRANT0: begin
        s_valid  = m0_valid;
        s_instr  = m0_instr;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready;
        m0_rdata = s_rdata;
      end
      GRANT1: begin
        s_valid  = m1_valid;
        s_instr  = m1_instr;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready;
        m1_rdata = s_rdata;
      end
      ERR_RESP: begin
        if (r_owner) begin
          m1_ready = 1'b1;
          m1_rdata = ERR_RDATA;
        end else begin
          m0_ready = 1'b1;
          m0_rdata = ERR_RDATA;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_cnt   <= 16'h0;
    end else begin
      if (w_granted) r_owner <= w_sel;
      if (!w_granted)    r_cnt <= 16'h0;
      else if (!s_ready) r_cnt <= r_cnt + 16'h1;
      if (w_done)                     r_last <= w_sel;
      else if (r_state == ERR_RESP)   r_last <= r_owner;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_flag   <= 1'b0;
      r_err_addr   <= 32'h0;
      r_err_master <= 1'b0;
    end else if (w_capture) begin
      r_err_flag   <= 1'b1;
      r_err_addr   <= w_maddr;
      r_err_master <= w_sel;
    end else if (err_clear) begin
      r_err_flag   <= 1'b0;
      r_err_addr   <= 32'h0;
      r_err_master <= 1'b0;
    end
  end

  assign err_flag   = r_err_flag;
  assign err_addr   = r_err_addr;
  assign err_master = r_err_master;

endmodule
